// File: rtl/pwm_bank_if.sv
// Register-write port of pwm_bank; the SPI peripheral drives the master side.
interface pwm_bank_if #(
    parameter int ADDR_W = 6
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/pwm_bank.sv
// Multi-channel PWM bank with double-buffered duties applied at period wrap.
// Optional prescaler (register 0x04) is built only when PWM_BANK_PRESCALE_EN is defined.
module pwm_bank #(
    parameter int NUM_CH = 16,
    parameter int RES    = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    pwm_bank_if.slave         bus,
    output logic [NUM_CH-1:0] out,
    output logic              period_tick
);
    localparam logic [RES-1:0]    CNT_MAX   = '1;
    localparam logic [ADDR_W-1:0] DUTY_BASE = ADDR_W'(16);

    logic [NUM_CH-1:0] en_out, en_pwm;
    logic [NUM_CH-1:0] en_out_q, en_pwm_q;
    logic [NUM_CH-1:0] pwm;
    logic [RES-1:0]    cnt;
    logic [RES-1:0]    duty_pend [NUM_CH];
    logic [RES-1:0]    duty_act  [NUM_CH];
    logic              tick, wrap, wrap_q;

`ifdef PWM_BANK_PRESCALE_EN
    logic [7:0] presc, pcnt;
    logic       presc_wr;

    assign presc_wr = bus.wr_en && (bus.wr_addr == ADDR_W'(4));
    assign tick     = (pcnt == presc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            pcnt  <= '0;
        end else if (presc_wr) begin
            presc <= bus.wr_data;
            pcnt  <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 8'd1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    assign wrap = tick && (cnt == CNT_MAX);

    // Each enable byte register covers channels 8*k .. 8*k+7; bits beyond NUM_CH do not exist.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_out <= '0;
            en_pwm <= '0;
        end else if (bus.wr_en) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            for (int c = 0; c < NUM_CH; c++) begin
                if (bus.wr_addr == ADDR_W'(c / 8))     en_out[c] <= bus.wr_data[3'(c)];
                if (bus.wr_addr == ADDR_W'(2 + c / 8)) en_pwm[c] <= bus.wr_data[3'(c)];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the duty arrays are small control registers, so they are reset like any flop.
            for (int c = 0; c < NUM_CH; c++) begin
                duty_pend[c] <= '0;
                duty_act[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (wrap) duty_act[c] <= duty_pend[c];
                if (bus.wr_en && (bus.wr_addr == DUTY_BASE + ADDR_W'(c)))
                    duty_pend[c] <= bus.wr_data[7 -: RES];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    cnt <= '0;
        else if (tick) cnt <= cnt + RES'(1);
    end

    always_comb begin
        // NOTE: assign a default before the loop so no path leaves pwm unassigned (no latch).
        pwm = '0;
        for (int c = 0; c < NUM_CH; c++)
            pwm[c] = (duty_act[c] == CNT_MAX) || (cnt < duty_act[c]);
    end

    // Enables pass through one staging flop so an enable write reaches out two clk after its edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_out_q    <= '0;
            en_pwm_q    <= '0;
            out         <= '0;
            wrap_q      <= 1'b0;
            period_tick <= 1'b0;
        end else begin
            en_out_q    <= en_out;
            en_pwm_q    <= en_pwm;
            out         <= en_out_q & (~en_pwm_q | pwm);
            wrap_q      <= wrap;
            period_tick <= wrap_q;
        end
    end
endmodule

// File: tb/tb_pwm_bank.sv
// Randomized and directed bench for pwm_bank against a per-edge behavioural model.
module tb_pwm_bank;
    localparam int NUM_CH = 16;
    localparam int RES    = 8;
    localparam int ADDR_W = 6;
    localparam int PERIOD = 1 << RES;
    localparam int MAXV   = PERIOD - 1;
    localparam int LIMIT  = 4096;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NUM_CH-1:0] out;
    logic              period_tick;

    pwm_bank_if #(.ADDR_W(ADDR_W)) bus ();

    pwm_bank #(.NUM_CH(NUM_CH), .RES(RES), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave), .out(out), .period_tick(period_tick)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model state: what the registers hold after the most recent edge.
    int                m_cnt, m_sub, m_presc;
    int                m_pend [NUM_CH];
    int                m_act  [NUM_CH];
    bit [15:0]         m_en_out, m_en_pwm, m_en_out_old, m_en_pwm_old;
    bit                m_wrap_last;
    logic [NUM_CH-1:0] m_out;
    logic              m_tick_out;

    task automatic model_reset();
        m_cnt = 0; m_sub = 0; m_presc = 0;
        for (int c = 0; c < NUM_CH; c++) begin m_pend[c] = 0; m_act[c] = 0; end
        m_en_out = '0; m_en_pwm = '0; m_en_out_old = '0; m_en_pwm_old = '0;
        m_wrap_last = 0; m_out = '0; m_tick_out = 0;
    endtask

    function automatic bit tick_now();
`ifdef PWM_BANK_PRESCALE_EN
        return m_sub == m_presc;
`else
        return 1'b1;
`endif
    endfunction

    function automatic bit wrap_next();
        return tick_now() && (m_cnt == MAXV);
    endfunction

    function automatic bit level(int c);
        if (m_act[c] == MAXV) return 1'b1;
        return m_cnt < m_act[c];
    endfunction

    task automatic model_edge(input bit we, input int a, input int d);
        bit tk, wr;
        tk = tick_now();
        wr = wrap_next();
        for (int c = 0; c < NUM_CH; c++)
            m_out[c] = m_en_out_old[c] && (!m_en_pwm_old[c] || level(c));
        m_tick_out  = m_wrap_last;
        m_wrap_last = wr;
        if (wr) for (int c = 0; c < NUM_CH; c++) m_act[c] = m_pend[c];
        if (tk) m_cnt = (m_cnt + 1) % PERIOD;
        m_sub = tk ? 0 : m_sub + 1;
        m_en_out_old = m_en_out;
        m_en_pwm_old = m_en_pwm;
        if (we) begin
            if (a == 0) m_en_out[7:0]  = 8'(d);
            if (a == 1) m_en_out[15:8] = 8'(d);
            if (a == 2) m_en_pwm[7:0]  = 8'(d);
            if (a == 3) m_en_pwm[15:8] = 8'(d);
`ifdef PWM_BANK_PRESCALE_EN
            if (a == 4) begin m_presc = d; m_sub = 0; end
`endif
            if (a >= 16 && a < 16 + NUM_CH) m_pend[a - 16] = d >> (8 - RES);
        end
        for (int c = NUM_CH; c < 16; c++) begin m_en_out[c] = 0; m_en_pwm[c] = 0; end
    endtask

    task automatic step(input bit we = 0, input int a = 0, input int d = 0);
        bus.wr_en   = we;
        bus.wr_addr = ADDR_W'(a);
        bus.wr_data = 8'(d);
        @(posedge clk);
        model_edge(we, a, d);
        #1;
        check("out", out, m_out);
        check("period_tick", period_tick, m_tick_out);
        bus.wr_en = 1'b0;
    endtask

    task automatic wr(input int a, input int d);
        step(1'b1, a, d);
    endtask

    // Measures one full period starting at a period_tick: length and high cycles of channel ch.
    task automatic measure(input int ch, output int high, output int len);
        int g = 0;
        while (!period_tick && g < LIMIT) begin step(); g++; end
        if (g >= LIMIT) check("period_tick_timeout", g, 0);
        high = 0; len = 0;
        do begin
            high += int'(out[ch]);
            len++;
            step();
        end while (!period_tick && len < LIMIT);
    endtask

    initial begin
        int n, high, len, g;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        model_reset();

        // 1. reset state, first tick latency, idle outputs
        #3;
        check("reset_out", out, 0);
        check("reset_tick", period_tick, 0);
        @(negedge clk); rst_n = 1'b1;
        n = 0;
        do begin step(); n++; end while (!period_tick && n < 400);
        check("first_tick_latency", n, 257);
        for (int i = n; i < 1000; i++) step();

        // 2. 50% on ch0
        wr(0, 8'h01); wr(2, 8'h01); wr(16, 8'h80);
        measure(0, high, len);
        check("ch0_len", len, PERIOD);
        check("ch0_high", high, 128);

        // 3. duty edge cases on ch1
        wr(0, 8'h03); wr(2, 8'h03);
        wr(17, 8'h00); measure(1, high, len); check("ch1_duty00", high, 0);
        wr(17, 8'hFF); measure(1, high, len); check("ch1_dutyFF", high, PERIOD);
        wr(17, 8'h01); measure(1, high, len); check("ch1_duty01", high, 1);

        // 4. static output on ch15, then disabled mid-period
        wr(1, 8'h80);
        step(); check("en15_on_1clk", out[15], 0);
        step(); check("en15_on_2clk", out[15], 1);
        repeat (20) step();
        wr(1, 8'h00);
        step(); check("en15_off_1clk", out[15], 1);
        step(); check("en15_off_2clk", out[15], 0);

        // 5. pending write on the wrap edge is deferred one period
        wr(17, 8'h80);
        measure(1, high, len);
        g = 0;
        while (!wrap_next() && g < LIMIT) begin step(); g++; end
        if (g >= LIMIT) check("wrap_wait_timeout", g, 0);
        wr(17, 8'h40);
        measure(1, high, len); check("wrapwrite_old", high, 128);
        measure(1, high, len); check("wrapwrite_new", high, 64);
        repeat (3) step();
        #2 rst_n = 1'b0;
        #1 check("rst_async_out", out, 0);
        model_reset();
        @(posedge clk); #1 check("rst_hold_out", out, 0);
        @(negedge clk); rst_n = 1'b1;

        // 6. prescaler (or its absence) on ch2
        wr(0, 8'h04); wr(2, 8'h04); wr(4, 3); wr(18, 8'h80);
        measure(2, high, len);
`ifdef PWM_BANK_PRESCALE_EN
        check("presc_len", len, 1024);
        check("presc_high", high, 512);
`else
        check("presc_len", len, PERIOD);
        check("presc_high", high, 128);
`endif

        // Randomized writes, including unmapped addresses
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) wr(int'($urandom_range(63)), int'($urandom_range(255)));
            else step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pwm_bank.md
Name: pwm_bank

Overview:
Parametrised multi-channel PWM generator, the successor to the fixed 16-output PWM peripheral. A simple register-write port (driven by the SPI peripheral) programs per-channel output enable, PWM enable and an independent duty cycle per channel. Duty updates are double-buffered and applied at period boundaries, so there are no glitched periods. A period strobe is exported for synchronising other logic.

Parameters:
NUM_CH, 16, number of output channels (1..16)
RES, 8, PWM resolution in bits (4..8); period = 2^RES counter ticks
ADDR_W, 6, register address width

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  register write strobe, one write per cycle when high
wr_addr  input  ADDR_W  register address
wr_data  input  8  register write data
out  output  NUM_CH  PWM / static channel outputs, registered
period_tick  output  1  one-cycle pulse on counter wrap, registered

Behaviour:
- Clocking and reset: single clock domain, clk. rst_n is asynchronous and active-low.
- Reset values: every register, every shadow duty, the counter and the prescaler count clear to 0. Both out and period_tick are 0.
- Register map (8-bit):
  - 0x00 EN_OUT[7:0]
  - 0x01 EN_OUT[15:8]
  - 0x02 EN_PWM[7:0]
  - 0x03 EN_PWM[15:8]
  - 0x04 PRESC (optional feature only)
  - 0x10+ch DUTY_PEND[ch] for ch = 0..NUM_CH-1
- Write rules:
  - A write lands on the clk edge where wr_en=1.
  - Unmapped addresses, channels >= NUM_CH, and EN bits >= NUM_CH are ignored. They are not stored and read as 0 internally.
  - DUTY_PEND keeps wr_data[7:8-RES], the top RES bits, so 8-bit software duty values scale across resolutions.
- Counter:
  - RES-bit up-counter that advances on each tick.
  - A tick is every clk cycle, or the prescaled rate when the optional feature is enabled.
  - Wraps from 2^RES-1 to 0.
- Shadow update:
  - On the tick where the counter wraps 2^RES-1 -> 0, every DUTY_ACT[ch] loads DUTY_PEND[ch].
  - A DUTY_PEND write in the same cycle as the wrap is not captured until the following wrap; the old pending value is loaded.
- Per-channel PWM level:
  - pwm = (counter < DUTY_ACT).
  - Exception: DUTY_ACT = all-ones (2^RES-1) forces pwm = 1 for the whole period (100%).
  - DUTY_ACT = 0 gives pwm = 0 for the whole period.
- Output mux, registered, one clk after the counter value:
  - out[ch] = EN_OUT[ch] ? (EN_PWM[ch] ? pwm : 1) : 0.
  - EN_OUT and EN_PWM take effect immediately; the affected out bit changes 2 clk after the write edge and is not synchronised to the period.
- period_tick: high for exactly one clk, in the cycle after the wrap tick, i.e. aligned with the first out sample of the new period.
- Reset mid-period: outputs go to 0 asynchronously. After release the counter restarts at 0 and all duties are 0, so software must reprogram.

Optional Feature:
- Macro: PWM_BANK_PRESCALE_EN.
- When defined:
  - Register 0x04 PRESC (8-bit, reset 0) is present.
  - An 8-bit prescale counter issues one tick every PRESC+1 clk cycles. PRESC=0 gives a tick every clk.
  - A PRESC write reloads the prescale counter to 0 on the same edge.
  - The output period is 2^RES*(PRESC+1) clk.
- When undefined:
  - A tick occurs every clk and no prescale logic is synthesised.
  - Writes to 0x04 are ignored.

Test Plan:
1. Reset, no writes (NUM_CH=16, RES=8) -> out=0x0000 for 1000 clk; period_tick pulses every 256 clk, first pulse 257 clk after reset release.
2. EN_OUT[0]=1, EN_PWM[0]=1, DUTY_PEND[0]=0x80 -> after the next wrap, out[0] is high 128 clk and low 128 clk per 256-clk period; no partial period before the wrap.
3. Duty edge cases on ch1 with both enables set: 0x00 -> constant 0; 0xFF -> constant 1; 0x01 -> high 1 clk per period.
4. EN_OUT[15]=1, EN_PWM[15]=0 -> out[15] static 1 starting 2 clk after the write. Then write EN_OUT[15:8]=0 -> out[15]=0 two clk later, mid-period.
5. Duty written in the wrap cycle (0x40 while the active duty is 0x80) -> the next period still uses 0x80 and the one after uses 0x40. Also, assert rst_n mid-period -> out=0 immediately, before the next clk.
6. PWM_BANK_PRESCALE_EN defined, PRESC=3, DUTY_PEND[2]=0x80 -> period 1024 clk, high 512 clk. Without the macro, a write to 0x04 leaves the period at 256 clk.
